l1_ld_mem_ctrl: RTL and testbench
=================================

Name: l1_ld_mem_ctrl

Overview:
- Initiator-side controller for the L1 load-data dual-port SRAM wrapper.
- Accepts read requests on a valid/ready channel and write requests on a valid channel.
- Drives the memory read port (REN/RADDR) and write port (WEN/WADDR/WDATA), and waits for the memory's post-reset ready.
- Returns read data in order on a valid/ready response channel, with a 2-entry skid buffer and same-cycle write-to-read forwarding.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 1024, number of memory words; address width is AW = $clog2(DEPTH).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; asynchronous, active-low
- RD_VAL  in  1  read request valid
- RD_RDY  out  1  read request accepted when RD_VAL & RD_RDY
- RD_ADDR  in  AW  read address
- WR_VAL  in  1  write request valid
- WR_RDY  out  1  write accepted when WR_VAL & WR_RDY
- WR_ADDR  in  AW  write address
- WR_DATA  in  WIDTH  write data
- RSP_VAL  out  1  read response valid
- RSP_RDY  in  1  consumer ready
- RSP_DATA  out  WIDTH  read response data
- RSP_ERR  out  1  parity error (tied 0 without the optional feature)
- M_READY  in  1  memory init done
- M_REN  out  1  memory read enable
- M_RADDR  out  AW  memory read address
- M_RDATA  in  MW  memory read data; valid the cycle after M_REN
- M_WEN  out  1  memory write enable
- M_WADDR  out  AW  memory write address
- M_WDATA  out  MW  memory write data
- MW is WIDTH, or WIDTH+1 with the optional feature.

Behaviour:
- States: INIT (reset value), RUN. INIT->RUN on the first cycle M_READY=1; RUN holds until reset.
- Reset values: RD_RDY=0, WR_RDY=0, RSP_VAL=0, RSP_DATA=0, RSP_ERR=0, M_REN=0, M_WEN=0. Skid buffer empty, s1_v=0.
- INIT: RD_RDY=0, WR_RDY=0, M_REN=0, M_WEN=0.
- Write path: WR_RDY = (state==RUN). M_WEN=WR_VAL&WR_RDY; M_WADDR=WR_ADDR; M_WDATA=WR_DATA. Combinational, no added latency.
- Read acceptance: RD_RDY = RUN & (cnt + s1_v < 2), where cnt is the skid occupancy (0..2). M_REN = RD_VAL&RD_RDY; M_RADDR=RD_ADDR.
- Stage s1: registered on accept (s1_v, addr). Also records fwd = (write accepted same cycle & WR_ADDR==RD_ADDR) and the forwarded data.
- Data at t+1: s1 data = fwd ? captured WR_DATA : M_RDATA. Write-first semantics.
- Response mux: RSP_VAL = (cnt>0) | s1_v. RSP_DATA = cnt>0 ? head : s1 data. Responses are strictly in order.
- Latency: read accepted at cycle t with an empty buffer and RSP_RDY=1 gives RSP_VAL at t+1.
- Push: s1 data goes into the skid buffer at end of cycle when s1_v & ~(cnt==0 & RSP_RDY).
- Pop: head pops when cnt>0 & RSP_RDY. Push and pop in the same cycle leave cnt unchanged.
- A write at t+1 to the address read at t does not affect that read's data.
- Full: cnt==2 (or cnt==1 with s1_v) forces RD_RDY=0. Throughput is 1 read/cycle while RSP_RDY=1.
- Pointers: 1-bit, wrap naturally.
- Async reset mid-operation: all state, in-flight reads and buffered responses are discarded; state returns to INIT.

Optional Feature:
- Macro: L1_LD_MEM_PARITY_EN.
- Enabled:
  - MW = WIDTH+1; M_WDATA = {^WR_DATA, WR_DATA}.
  - On read, err = ^M_RDATA (odd parity over all MW bits); a forwarded read gives err=0.
  - err is carried with the data through the buffer; RSP_ERR is valid with RSP_VAL.
  - A zero-cleared word (after memory init) reads as err=0.
- Disabled: MW = WIDTH, RSP_ERR tied 0, no parity logic.

Test Plan:
- Init: M_READY held 0 for 1024 cycles, RD_VAL=WR_VAL=1 -> RD_RDY=WR_RDY=0 and M_REN=M_WEN=0 throughout; both RDY=1 the cycle after M_READY=1.
- Write then read: write 0xDEADBEEF to 0x010 at t, read 0x010 at t+1 -> RSP_VAL at t+2, RSP_DATA=0xDEADBEEF.
- Same-cycle forward: write 0x12345678 and read addr 0x3FF in the same cycle, memory model returns old 0 -> RSP_DATA=0x12345678.
- Backpressure: RSP_RDY=0, reads to 0,1,2 back-to-back -> only 2 accepted, RD_RDY=0 after; raise RSP_RDY -> data of 0,1 returned in order, then read 2 accepted.
- Reset mid-flight: 2 responses buffered, pulse RST_N low -> RSP_VAL=0 immediately, state INIT until M_READY.
- Parity (L1_LD_MEM_PARITY_EN): model flips one bit of stored word 0x5 -> RSP_ERR=1 with that response; clean words give RSP_ERR=0.

Source files
------------

// File: rtl/l1_ld_mem_ctrl.sv
// L1 load-data SRAM initiator: read/write issue, 2-entry response skid, write forwarding.
// Define L1_LD_MEM_PARITY_EN to store a parity bit per word and report RSP_ERR.
module l1_ld_mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
`ifdef L1_LD_MEM_PARITY_EN
  localparam int MW = WIDTH + 1
`else
  localparam int MW = WIDTH
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RD_VAL,
  output logic             RD_RDY,
  input  logic [AW-1:0]    RD_ADDR,
  input  logic             WR_VAL,
  output logic             WR_RDY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             RSP_VAL,
  input  logic             RSP_RDY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR,
  input  logic             M_READY,
  output logic             M_REN,
  output logic [AW-1:0]    M_RADDR,
  input  logic [MW-1:0]    M_RDATA,
  output logic             M_WEN,
  output logic [AW-1:0]    M_WADDR,
  output logic [MW-1:0]    M_WDATA
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_fwd_q, s1_fwd_d;
  logic [WIDTH-1:0] s1_wd_q, s1_wd_d;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       occ;
  logic             run, rd_acc, wr_acc, push, pop;

  assign run    = (state_q == RUN);
  assign occ    = cnt_q + {1'b0, s1_v_q};
  assign RD_RDY = run & (occ < 2'd2);
  assign WR_RDY = run;
  assign rd_acc = RD_VAL & RD_RDY;
  assign wr_acc = WR_VAL & WR_RDY;

  assign M_REN   = rd_acc;
  assign M_RADDR = RD_ADDR;
  assign M_WEN   = wr_acc;
  assign M_WADDR = WR_ADDR;

  // forwarded data overrides the stale word the SRAM returns
  assign s1_data = s1_fwd_q ? s1_wd_q : M_RDATA[WIDTH-1:0];
  assign push    = s1_v_q & ~((cnt_q == 2'd0) & RSP_RDY);
  assign pop     = (cnt_q != 2'd0) & RSP_RDY;

  assign RSP_VAL  = (cnt_q != 2'd0) | s1_v_q;
  assign RSP_DATA = (cnt_q != 2'd0) ? buf_q[rp_q] :
                    (s1_v_q ? s1_data : '0);

`ifdef L1_LD_MEM_PARITY_EN
  logic s1_err;
  logic err_q [2];
  logic err_d [2];

  assign M_WDATA = {^WR_DATA, WR_DATA};
  assign s1_err  = ~s1_fwd_q & (^M_RDATA);
  assign RSP_ERR = (cnt_q != 2'd0) ? err_q[rp_q] :
                   (s1_v_q & s1_err);

  always_comb begin
    err_d = err_q;
    if (push) err_d[wp_q] = s1_err;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q[0] <= 1'b0;
      err_q[1] <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign M_WDATA = WR_DATA;
  assign RSP_ERR = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    if (state_q == INIT && M_READY) state_d = RUN;
    s1_v_d   = rd_acc;
    s1_fwd_d = rd_acc ? (wr_acc & (WR_ADDR == RD_ADDR)) : s1_fwd_q;
    s1_wd_d  = rd_acc ? WR_DATA : s1_wd_q;
    buf_d    = buf_q;
    if (push) buf_d[wp_q] = s1_data;
    wp_d     = wp_q ^ push;
    rp_d     = rp_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= INIT;
      s1_v_q   <= 1'b0;
      s1_fwd_q <= 1'b0;
      s1_wd_q  <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      s1_v_q   <= s1_v_d;
      s1_fwd_q <= s1_fwd_d;
      s1_wd_q  <= s1_wd_d;
      buf_q    <= buf_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_l1_ld_mem_ctrl.sv
// Scoreboard bench for l1_ld_mem_ctrl with a behavioural read-old-data SRAM.
module tb_l1_ld_mem_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
`ifdef L1_LD_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rd_val, rd_rdy, wr_val, wr_rdy;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WIDTH-1:0] wr_data, rsp_data;
  logic rsp_val, rsp_rdy, rsp_err;
  logic m_ready, m_ren, m_wen;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [MW-1:0] m_rdata, m_wdata;
  logic mem_clr, flip;
  logic [MW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;
  logic [WIDTH:0] exp_q [$];

  always #5 clk = ~clk;

  l1_ld_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_N(rst_n),
    .RD_VAL(rd_val), .RD_RDY(rd_rdy), .RD_ADDR(rd_addr),
    .WR_VAL(wr_val), .WR_RDY(wr_rdy), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data),
    .RSP_VAL(rsp_val), .RSP_RDY(rsp_rdy), .RSP_DATA(rsp_data),
    .RSP_ERR(rsp_err),
    .M_READY(m_ready), .M_REN(m_ren), .M_RADDR(m_raddr),
    .M_RDATA(m_rdata), .M_WEN(m_wen), .M_WADDR(m_waddr),
    .M_WDATA(m_wdata)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      m_rdata <= '0;
    end else begin
      if (m_ren) m_rdata <= mem[m_raddr];
      if (m_wen) mem[m_waddr] <= m_wdata;
      if (flip) mem[5] <= mem[5] ^ MW'(8);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_val && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%0h required=none", rsp_data);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e[WIDTH-1:0]));
        chk("rsp_err", 64'(rsp_err), 64'(e[WIDTH]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_val = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_val = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; mem_clr = 1'b1; flip = 1'b0;
    rd_val = 1'b0; wr_val = 1'b0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; rsp_rdy = 1'b1; m_ready = 1'b0;
    #2;
    chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_wr_rdy", wr_rdy, 0);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_m_ren", m_ren, 0);
    chk("rst_m_wen", m_wen, 0);
    tick(); tick();
    mem_clr = 1'b0;
    rst_n = 1'b1;

    rd_val = 1'b1; wr_val = 1'b1; wr_data = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      seen = seen | rd_rdy | wr_rdy | m_ren | m_wen;
    end
    chk("init_quiet", seen, 0);
    m_ready = 1'b1;
    chk("rdy_before_run", rd_rdy, 0);
    tick();
    rd_val = 1'b0; wr_val = 1'b0;
    chk("run_rd_rdy", rd_rdy, 1);
    chk("run_wr_rdy", wr_rdy, 1);

    // write then read next cycle
    wr_val = 1'b1; wr_addr = 10'h010; wr_data = 32'hDEADBEEF;
    chk("m_wen", m_wen, 1);
    chk("m_waddr", m_waddr, 10'h010);
    tick();
    wr_val = 1'b0;
    rd_val = 1'b1; rd_addr = 10'h010;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    chk("lat_t1_rsp_val", rsp_val, 0);
    tick();
    rd_val = 1'b0;
    chk("lat_t2_rsp_val", rsp_val, 1);
    tick(); tick();

    // same-cycle forward, SRAM still holds 0
    wr_val = 1'b1; wr_addr = 10'h3FF; wr_data = 32'h12345678;
    rd_val = 1'b1; rd_addr = 10'h3FF;
    exp_q.push_back({1'b0, 32'h12345678});
    tick();
    wr_val = 1'b0; rd_val = 1'b0;
    tick(); tick();

    // back-to-back reads at full rate
    for (int i = 0; i < 4; i++) wr(10'(32'h20 + i), 32'h1000_0020 + i);
    for (int i = 0; i < 4; i++) begin
      rd_val = 1'b1; rd_addr = 10'(32'h20 + i);
      chk("thru_rd_rdy", rd_rdy, 1);
      exp_q.push_back({1'b0, 32'h1000_0020 + i});
      tick();
    end
    rd_val = 1'b0;
    tick(); tick(); tick();

    // backpressure
    wr(10'h000, 32'hA0A0_0000);
    wr(10'h001, 32'hA1A1_0001);
    wr(10'h002, 32'hA2A2_0002);
    rsp_rdy = 1'b0;
    rd_val = 1'b1; rd_addr = 10'h000;
    chk("bp_rdy0", rd_rdy, 1);
    exp_q.push_back({1'b0, 32'hA0A0_0000});
    tick();
    rd_addr = 10'h001;
    chk("bp_rdy1", rd_rdy, 1);
    exp_q.push_back({1'b0, 32'hA1A1_0001});
    tick();
    rd_addr = 10'h002;
    chk("bp_rdy2_blocked", rd_rdy, 0);
    tick();
    chk("bp_full_blocked", rd_rdy, 0);
    chk("bp_rsp_val", rsp_val, 1);
    tick();
    rsp_rdy = 1'b1;
    chk("bp_release_blocked", rd_rdy, 0);
    tick();
    chk("bp_rdy2_accept", rd_rdy, 1);
    exp_q.push_back({1'b0, 32'hA2A2_0002});
    tick();
    rd_val = 1'b0;
    tick(); tick(); tick();

    // reset with two responses buffered
    rsp_rdy = 1'b0;
    rd_val = 1'b1; rd_addr = 10'h020;
    tick();
    rd_addr = 10'h021;
    tick();
    rd_val = 1'b0;
    tick();
    chk("mf_rsp_val_before", rsp_val, 1);
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mf_rsp_val_async", rsp_val, 0);
    chk("mf_rd_rdy_async", rd_rdy, 0);
    #3 rst_n = 1'b1;
    rsp_rdy = 1'b1;
    tick(); tick(); tick();
    chk("mf_init_hold", rd_rdy, 0);
    m_ready = 1'b1;
    tick();
    chk("mf_run_again", rd_rdy, 1);
    rd_val = 1'b1; rd_addr = 10'h010;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    rd_val = 1'b0;
    tick(); tick();

`ifdef L1_LD_MEM_PARITY_EN
    wr(10'h005, 32'h0F0F_0F0F);
    wr(10'h006, 32'h0000_0003);
    flip = 1'b1;
    tick();
    flip = 1'b0;
    rd_val = 1'b1; rd_addr = 10'h005;
    exp_q.push_back({1'b1, 32'h0F0F_0F07});
    tick();
    rd_addr = 10'h006;
    exp_q.push_back({1'b0, 32'h0000_0003});
    tick();
    rd_val = 1'b0;
    tick(); tick();
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("drain", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
